// File: rtl/keypad_pkg.sv
// Shared constants for the keypad scanner: key codes, row/column decode and the
// debounce state encoding.
package keypad_pkg;

  localparam logic [3:0] KEY_UP    = 4'd2;
  localparam logic [3:0] KEY_LEFT  = 4'd4;
  localparam logic [3:0] KEY_RIGHT = 4'd6;
  localparam logic [3:0] KEY_DOWN  = 4'd8;

  localparam int unsigned NUM_ROWS = 6;
  localparam int unsigned NUM_KEYS = 4;

  // Indexed by key: 0 up, 1 left, 2 right, 3 down (matches key_held bit order).
  localparam logic [2:0] KEY_ROW  [NUM_KEYS] = '{3'd0, 3'd1, 3'd1, 3'd2};
  localparam logic [2:0] KEY_COL  [NUM_KEYS] = '{3'b101, 3'b011, 3'b110, 3'b101};
  localparam logic [3:0] KEY_CODE [NUM_KEYS] = '{KEY_UP, KEY_LEFT, KEY_RIGHT, KEY_DOWN};

  typedef enum logic [1:0] {
    StIdle,
    StPressChk,
    StHeld,
    StRelChk
  } deb_state_e;

endpackage

// File: rtl/key_debounce_fsm.sv
// Per-key debouncer: accepts a press or release after DEB_FRAMES consecutive
// agreeing samples and pulses push on the single transition into the held state.
module key_debounce_fsm
  import keypad_pkg::*;
#(
  parameter int unsigned DEB_FRAMES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic pressed,
  output logic held,
  output logic push
);

  localparam logic [3:0] DebCount = 4'(DEB_FRAMES);

  deb_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The sample that leaves IDLE/HELD counts as the first of the run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    if (sample) begin
      unique case (state_q)
        StIdle: begin
          if (pressed) begin
            if (DebCount == 4'd1) begin
              state_d = StHeld;
              push    = 1'b1;
            end else begin
              state_d = StPressChk;
              cnt_d   = 4'd1;
            end
          end
        end
        StPressChk: begin
          if (!pressed) begin
            state_d = StIdle;
            cnt_d   = 4'd0;
          end else if (cnt_q + 4'd1 == DebCount) begin
            state_d = StHeld;
            cnt_d   = 4'd0;
            push    = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        StHeld: begin
          if (!pressed) begin
            if (DebCount == 4'd1) begin
              state_d = StIdle;
            end else begin
              state_d = StRelChk;
              cnt_d   = 4'd1;
            end
          end
        end
        StRelChk: begin
          if (pressed) begin
            state_d = StHeld;
            cnt_d   = 4'd0;
          end else if (cnt_q + 4'd1 == DebCount) begin
            state_d = StIdle;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  assign held = (state_q == StHeld) || (state_q == StRelChk);

endmodule

// File: rtl/keypad_event_queue.sv
// Row-scanning keypad front end: scans six rows, debounces four keys and queues
// one press event per accepted press in a FIFO with a valid/ready consumer port.
module keypad_event_queue
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 16,
  parameter int unsigned DEB_FRAMES = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] col,
  output logic [2:0] row_sel,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic [3:0] key_held,
  output logic       overflow
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [2:0] RowLast = 3'(NUM_ROWS - 1);
  localparam logic [PtrW:0] CntFull = (PtrW + 1)'(FIFO_DEPTH);

  logic [DivW-1:0] div_q;
  logic [2:0]      row_q;
  logic            sample_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      row_q <= 3'd0;
    end else if (div_q == DivLast) begin
      div_q <= '0;
      row_q <= (row_q == RowLast) ? 3'd0 : row_q + 3'd1;
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

  assign sample_tick = (div_q == DivLast);
  assign row_sel     = row_q;

  logic [NUM_KEYS-1:0] key_push;
  logic [NUM_KEYS-1:0] held;

  for (genvar k = 0; k < int'(NUM_KEYS); k++) begin : g_key
    key_debounce_fsm #(
      .DEB_FRAMES(DEB_FRAMES)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .sample (sample_tick && (row_q == KEY_ROW[k])),
      .pressed(col == KEY_COL[k]),
      .held   (held[k]),
      .push   (key_push[k])
    );
  end

  assign key_held = held;

  // Only one row is sampled per cycle and one column pattern can match, so at
  // most one bit of key_push is ever set.
  logic       push;
  logic [3:0] push_code;

  always_comb begin
    push      = 1'b0;
    push_code = 4'd0;
    for (int k = 0; k < int'(NUM_KEYS); k++) begin
      if (key_push[k]) begin
        push      = 1'b1;
        push_code = KEY_CODE[k];
      end
    end
  end

  logic [3:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_q, rd_q;
  logic [PtrW:0]   cnt_q;
  logic            full, pop, wr_en, ovf_q;

  assign key_valid = (cnt_q != '0);
  assign full      = (cnt_q == CntFull);
  assign pop       = key_valid && key_ready;
  assign wr_en     = push && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= 4'd0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= push_code;
        wr_q        <= wr_q + PtrW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PtrW'(1);
      end
      unique case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + (PtrW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (PtrW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push && full && !pop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign key_code = mem_q[rd_q];
  assign overflow = ovf_q;

endmodule

// File: tb/tb_keypad_event_queue.sv
// Randomized self-checking bench for keypad_event_queue against a frame-level
// debounce model and a queue-based event model.
module tb_keypad_event_queue;

  localparam int SD = 4;
  localparam int DF = 2;
  localparam int FD = 4;
  localparam int FRAME = SD * 6;

  localparam int         K_ROW  [4] = '{0, 1, 1, 2};
  localparam logic [2:0] K_COL  [4] = '{3'b101, 3'b011, 3'b110, 3'b101};
  localparam logic [3:0] K_CODE [4] = '{4'd2, 4'd4, 4'd6, 4'd8};

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] col;
  logic [2:0] row_sel;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [3:0] key_held;
  logic       overflow;

  keypad_event_queue #(
    .SCAN_DIV  (SD),
    .DEB_FRAMES(DF),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .col      (col),
    .row_sel  (row_sel),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ready(key_ready),
    .key_held (key_held),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int         mcyc;
  bit         m_held [4];
  int         m_streak [4];
  bit         m_ovf;
  logic [3:0] mq[$];
  logic [3:0] got[$];
  logic [3:0] exp_pop[$];

  int press_k;
  bit ready;

  function automatic void model_clear();
    mcyc = 0;
    m_ovf = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_held[k] = 1'b0;
      m_streak[k] = 0;
    end
    mq.delete();
    got.delete();
    exp_pop.delete();
  endfunction

  function automatic logic [3:0] model_held();
    return {m_held[3], m_held[2], m_held[1], m_held[0]};
  endfunction

  function automatic logic [2:0] exp_row();
    return 3'((mcyc / SD) % 6);
  endfunction

  // One clock: drive inputs, advance the model, land 1 time unit after the edge.
  task automatic tick();
    int mdiv, mrow;
    bit mpop, mpush, gpop, p;
    logic [3:0] mcode, gcode;
    mdiv = mcyc % SD;
    mrow = (mcyc / SD) % 6;
    col = 3'b111;
    if (press_k >= 0 && mrow == K_ROW[press_k]) col = K_COL[press_k];
    key_ready = ready;
    mpop = ready && (mq.size() > 0);
    gpop = key_valid && key_ready;
    gcode = key_code;
    mpush = 1'b0;
    mcode = 4'd0;
    if (mdiv == SD - 1) begin
      for (int k = 0; k < 4; k++) begin
        if (mrow == K_ROW[k]) begin
          p = (press_k == k);
          if (p != m_held[k]) begin
            m_streak[k]++;
            if (m_streak[k] == DF) begin
              m_held[k] = p;
              m_streak[k] = 0;
              if (p) begin
                mpush = 1'b1;
                mcode = K_CODE[k];
              end
            end
          end else begin
            m_streak[k] = 0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    if (gpop) got.push_back(gcode);
    if (mpop) exp_pop.push_back(mq.pop_front());
    if (mpush) begin
      if (mq.size() < FD) mq.push_back(mcode);
      else m_ovf = 1'b1;
    end
    mcyc++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    press_k = -1;
    ready = 1'b0;
    col = 3'b111;
    key_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  // Press key k (or -1) for n cycles with per-cycle checks against the model.
  task automatic run_key(input int k, input int n);
    press_k = k;
    for (int c = 0; c < n; c++) begin
      tick();
      vectors++;
      if (key_held !== model_held()) begin
        miscompares++;
        $display("FAIL run_held cyc=%0d got=%b exp=%b", mcyc, key_held, model_held());
      end
      vectors++;
      if (key_valid !== (mq.size() > 0)) begin
        miscompares++;
        $display("FAIL run_valid cyc=%0d got=%b exp=%b", mcyc, key_valid, mq.size() > 0);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    vectors += 5;
    if (row_sel !== 3'd0) begin miscompares++; $display("FAIL rst_row got=%0d exp=0", row_sel); end
    if (key_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got=%b exp=0", key_valid); end
    if (key_code !== 4'd0) begin miscompares++; $display("FAIL rst_code got=%0d exp=0", key_code); end
    if (key_held !== 4'd0) begin miscompares++; $display("FAIL rst_held got=%b exp=0", key_held); end
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_scan();
    apply_reset();
    press_k = -1;
    for (int c = 0; c < 100; c++) begin
      tick();
      vectors++;
      if (row_sel !== exp_row()) begin
        miscompares++;
        $display("FAIL scan_row cyc=%0d got=%0d exp=%0d", mcyc, row_sel, exp_row());
      end
      vectors++;
      if (key_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL scan_valid cyc=%0d got=%b exp=0", mcyc, key_valid);
      end
    end
  endtask

  task automatic test_left();
    apply_reset();
    ready = 1'b1;
    run_key(1, 5 * FRAME);
    vectors++;
    if (key_held[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL left_held got=%b exp=1", key_held[1]);
    end
    run_key(-1, 2 * FRAME);
    vectors++;
    if (key_held[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL left_release got=%b exp=0", key_held[1]);
    end
    vectors++;
    if (got.size() !== 1 || (got.size() == 1 && got[0] !== 4'd4)) begin
      miscompares++;
      $display("FAIL left_events count=%0d first=%0d exp count=1 code=4",
               got.size(), got.size() > 0 ? got[0] : 4'd0);
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    ready = 1'b1;
    run_key(3, FRAME);
    run_key(-1, 2 * FRAME);
    vectors++;
    if (got.size() !== 0 || key_held !== 4'd0) begin
      miscompares++;
      $display("FAIL glitch events=%0d held=%b exp events=0 held=0", got.size(), key_held);
    end
  endtask

  task automatic test_overflow();
    int seq [5] = '{0, 2, 3, 1, 0};
    logic [3:0] want [4] = '{4'd2, 4'd6, 4'd8, 4'd4};
    apply_reset();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_key(seq[i], 3 * FRAME);
      run_key(-1, 3 * FRAME);
    end
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_flag got=%b exp=1", overflow);
    end
    vectors++;
    if (key_code !== 4'd2) begin
      miscompares++;
      $display("FAIL ovf_head got=%0d exp=2", key_code);
    end
    ready = 1'b1;
    run_key(-1, 10);
    vectors++;
    if (got.size() !== 4) begin
      miscompares++;
      $display("FAIL ovf_drain_count got=%0d exp=4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== want[i]) begin
        miscompares++;
        $display("FAIL ovf_drain_order idx=%0d got=%0d exp=%0d", i, got[i], want[i]);
      end
    end
    vectors++;
    if (overflow !== 1'b1 || key_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_after_drain ovf=%b valid=%b exp ovf=1 valid=0", overflow, key_valid);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    ready = 1'b0;
    run_key(0, 3 * FRAME);
    run_key(-1, 3 * FRAME);
    for (int c = 0; c < 20; c++) begin
      tick();
      vectors++;
      if (key_valid !== 1'b1 || key_code !== 4'd2) begin
        miscompares++;
        $display("FAIL stall_hold cyc=%0d valid=%b code=%0d exp valid=1 code=2",
                 c, key_valid, key_code);
      end
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    vectors++;
    if (key_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_pop got=%b exp=0", key_valid);
    end
  endtask

  task automatic test_reset_mid();
    int budget;
    apply_reset();
    ready = 1'b0;
    run_key(0, 3 * FRAME);
    run_key(-1, 3 * FRAME);
    run_key(3, 3 * FRAME);
    run_key(-1, 3 * FRAME);
    vectors++;
    if (mq.size() != 2 || key_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_setup queued=%0d valid=%b exp queued=2 valid=1", mq.size(), key_valid);
    end
    budget = 0;
    press_k = 2;
    while (m_streak[2] != 1 && budget < 2 * FRAME) begin
      tick();
      budget++;
    end
    vectors++;
    if (m_streak[2] != 1) begin
      miscompares++;
      $display("FAIL mid_presschk_timeout cycles=%0d exp reached", budget);
    end
    rst = 1'b1;
    #2;
    vectors++;
    if (row_sel !== 3'd0 || key_valid !== 1'b0 || key_code !== 4'd0 ||
        key_held !== 4'd0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_rst row=%0d valid=%b code=%0d held=%b ovf=%b exp all 0",
               row_sel, key_valid, key_code, key_held, overflow);
    end
    press_k = -1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    run_key(-1, 3 * FRAME);
    vectors++;
    if (key_valid !== 1'b0 || key_held !== 4'd0) begin
      miscompares++;
      $display("FAIL mid_after valid=%b held=%b exp 0", key_valid, key_held);
    end
  endtask

  task automatic test_random();
    int dur;
    apply_reset();
    for (int s = 0; s < 40; s++) begin
      press_k = int'($urandom_range(0, 4)) - 1;
      dur = int'($urandom_range(8, 90));
      for (int c = 0; c < dur; c++) begin
        ready = ($urandom_range(0, 2) == 0);
        tick();
        vectors++;
        if (row_sel !== exp_row()) begin
          miscompares++;
          $display("FAIL rnd_row cyc=%0d got=%0d exp=%0d", mcyc, row_sel, exp_row());
        end
        vectors++;
        if (key_held !== model_held()) begin
          miscompares++;
          $display("FAIL rnd_held cyc=%0d got=%b exp=%b", mcyc, key_held, model_held());
        end
        vectors++;
        if (key_valid !== (mq.size() > 0)) begin
          miscompares++;
          $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", mcyc, key_valid, mq.size() > 0);
        end
        if (mq.size() > 0) begin
          vectors++;
          if (key_code !== mq[0]) begin
            miscompares++;
            $display("FAIL rnd_code cyc=%0d got=%0d exp=%0d", mcyc, key_code, mq[0]);
          end
        end
        vectors++;
        if (overflow !== m_ovf) begin
          miscompares++;
          $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", mcyc, overflow, m_ovf);
        end
      end
    end
    vectors++;
    if (got.size() != exp_pop.size()) begin
      miscompares++;
      $display("FAIL rnd_pop_count got=%0d exp=%0d", got.size(), exp_pop.size());
    end
    for (int i = 0; i < got.size() && i < exp_pop.size(); i++) begin
      vectors++;
      if (got[i] !== exp_pop[i]) begin
        miscompares++;
        $display("FAIL rnd_pop_seq idx=%0d got=%0d exp=%0d", i, got[i], exp_pop[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    col = 3'b111;
    key_ready = 1'b0;
    press_k = -1;
    ready = 1'b0;
    model_clear();
    test_reset();
    test_scan();
    test_left();
    test_glitch();
    test_overflow();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
